// File: rtl/accel_dmem_responder.sv
// Responder for the accelerator memory-request interface: serializes read and
// write bursts onto a word-addressed synchronous DMem port. Reads go through a 2-entry FIFO.
module accel_dmem_responder #(
   parameter int unsigned AWIDTH     = 32,
   parameter int unsigned DWIDTH     = 32,
   parameter int unsigned MEM_AWIDTH = 14
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [AWIDTH-1:0]     req_read_addr,
   input  logic                  req_read_addr_valid,
   output logic                  req_read_addr_ready,
   input  logic [31:0]           req_read_len,
   output logic [DWIDTH-1:0]     req_read_data,
   output logic                  req_read_data_valid,
   input  logic                  req_read_data_ready,
   input  logic [AWIDTH-1:0]     req_write_addr,
   input  logic                  req_write_addr_valid,
   output logic                  req_write_addr_ready,
   input  logic [31:0]           req_write_len,
   input  logic [DWIDTH-1:0]     req_write_data,
   input  logic                  req_write_data_valid,
   output logic                  req_write_data_ready,
   output logic                  resp_write_status,
   output logic                  resp_write_status_valid,
   input  logic                  resp_write_status_ready,
   output logic [MEM_AWIDTH-1:0] mem_addr,
   output logic                  mem_en,
   output logic [DWIDTH/8-1:0]   mem_we,
   output logic [DWIDTH-1:0]     mem_din,
   input  logic [DWIDTH-1:0]     mem_dout
);
   localparam int unsigned LEN_W = 32;
   localparam logic [AWIDTH-1:0] MEM_WORDS = AWIDTH'(1) << MEM_AWIDTH;

   typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, WRESP = 2'd3} state_t;

   state_t              state_q, state_d;
   logic                rr_write_q;
   logic [AWIDTH-1:0]   base_q;
   logic [LEN_W-1:0]    rem_q;
   logic [LEN_W-1:0]    beat_q;
   logic                err_q;
   logic                inflight_q;
   logic                inflight_oor_q;
   logic [DWIDTH-1:0]   fifo_q [2];
   logic                wr_ptr_q;
   logic                rd_ptr_q;
   logic [1:0]          count_q;
   logic                status_q;
   logic                status_valid_q;

   logic                grant_rd;
   logic                grant_wr;
   logic [AWIDTH-1:0]   beat_addr;
   logic                beat_oor;
   logic                rd_deq;
   logic [2:0]          rd_outstanding;
   logic                rd_issue;
   logic                wr_fire;
   logic                rd_done;
   logic [LEN_W-1:0]    grant_len;

   // Arbitration: round-robin only matters when both channels request together
   assign grant_wr = !rst && (state_q == IDLE) && req_write_addr_valid
                     && (!req_read_addr_valid || rr_write_q);
   assign grant_rd = !rst && (state_q == IDLE) && req_read_addr_valid
                     && (!req_write_addr_valid || !rr_write_q);
   assign grant_len = grant_wr ? req_write_len : req_read_len;

   assign beat_addr = base_q + AWIDTH'(beat_q);
   assign beat_oor  = (beat_addr >= MEM_WORDS);

   // A dequeue this cycle frees a slot, which keeps reads at one beat per cycle
   assign rd_deq         = (count_q != 2'd0) && req_read_data_ready;
   assign rd_outstanding = 3'(count_q) + 3'(inflight_q) - 3'(rd_deq);
   assign rd_issue       = (state_q == RD) && (rem_q != '0) && (rd_outstanding < 3'd2);
   assign wr_fire        = (state_q == WR) && (rem_q != '0) && req_write_data_valid;
   assign rd_done        = (rem_q == '0) && !inflight_q
                           && ((count_q == 2'd0) || ((count_q == 2'd1) && rd_deq));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_wr) state_d = WR;
                  else if (grant_rd) state_d = RD;
         RD:      if (rd_done) state_d = IDLE;
         WR:      if (wr_fire && (rem_q == LEN_W'(1))) state_d = WRESP;
         WRESP:   if (status_valid_q && resp_write_status_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_read_addr_ready     = grant_rd;
      req_write_addr_ready    = grant_wr;
      req_write_data_ready    = (state_q == WR) && (rem_q != '0);
      req_read_data_valid     = (count_q != 2'd0);
      req_read_data           = fifo_q[rd_ptr_q];
      resp_write_status       = status_q;
      resp_write_status_valid = status_valid_q;
      mem_addr                = beat_addr[MEM_AWIDTH-1:0];
      mem_din                 = req_write_data;
      mem_en                  = (rd_issue || wr_fire) && !beat_oor;
      mem_we                  = '0;
      if (wr_fire && !beat_oor) mem_we = '1;
   end

   // Request bookkeeping, read FIFO and write status
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_write_q     <= 1'b1;
         base_q         <= '0;
         rem_q          <= '0;
         beat_q         <= '0;
         err_q          <= 1'b0;
         inflight_q     <= 1'b0;
         inflight_oor_q <= 1'b0;
         fifo_q[0]      <= '0;
         fifo_q[1]      <= '0;
         wr_ptr_q       <= 1'b0;
         rd_ptr_q       <= 1'b0;
         count_q        <= 2'd0;
         status_q       <= 1'b0;
         status_valid_q <= 1'b0;
      end else begin
         if (grant_wr || grant_rd) begin
            base_q     <= grant_wr ? req_write_addr : req_read_addr;
            rem_q      <= (grant_len == '0) ? LEN_W'(1) : grant_len;
            beat_q     <= '0;
            err_q      <= 1'b0;
            rr_write_q <= grant_rd;
         end else if (rd_issue || wr_fire) begin
            rem_q  <= rem_q - LEN_W'(1);
            beat_q <= beat_q + LEN_W'(1);
            if (wr_fire && beat_oor) err_q <= 1'b1;
         end
         inflight_q     <= rd_issue;
         inflight_oor_q <= beat_oor;
         if (inflight_q) begin
            fifo_q[wr_ptr_q] <= inflight_oor_q ? '0 : mem_dout;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (rd_deq) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + 2'(inflight_q) - 2'(rd_deq);
         if (wr_fire && (rem_q == LEN_W'(1))) status_q <= ~(err_q | beat_oor);
         status_valid_q <= (state_d == WRESP);
      end
   end

endmodule

// File: tb/tb_accel_dmem_responder.sv
// Directed bench for accel_dmem_responder with a behavioural synchronous DMem.
module tb_accel_dmem_responder;
   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;
   localparam int unsigned MAW   = 14;
   localparam int unsigned DEPTH = 1 << MAW;

   logic            clk = 1'b0;
   logic            rst;
   logic [AW-1:0]   req_read_addr;
   logic            req_read_addr_valid;
   logic            req_read_addr_ready;
   logic [31:0]     req_read_len;
   logic [DW-1:0]   req_read_data;
   logic            req_read_data_valid;
   logic            req_read_data_ready;
   logic [AW-1:0]   req_write_addr;
   logic            req_write_addr_valid;
   logic            req_write_addr_ready;
   logic [31:0]     req_write_len;
   logic [DW-1:0]   req_write_data;
   logic            req_write_data_valid;
   logic            req_write_data_ready;
   logic            resp_write_status;
   logic            resp_write_status_valid;
   logic            resp_write_status_ready;
   logic [MAW-1:0]  mem_addr;
   logic            mem_en;
   logic [DW/8-1:0] mem_we;
   logic [DW-1:0]   mem_din;
   logic [DW-1:0]   mem_dout;

   logic [DW-1:0]   mem [DEPTH];

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int issued = 0;
   int taken = 0;
   int max_out = 0;

   logic [31:0]     rbuf [16];
   int              rcyc [16];
   int              rfire_cyc;
   int              grant_wait;
   logic            wen [4];
   logic [DW/8-1:0] wwe [4];
   logic [MAW-1:0]  waddr [4];

   always #5 clk = ~clk;

   accel_dmem_responder #(.AWIDTH(AW), .DWIDTH(DW), .MEM_AWIDTH(MAW)) dut (
      .clk(clk), .rst(rst),
      .req_read_addr(req_read_addr), .req_read_addr_valid(req_read_addr_valid),
      .req_read_addr_ready(req_read_addr_ready), .req_read_len(req_read_len),
      .req_read_data(req_read_data), .req_read_data_valid(req_read_data_valid),
      .req_read_data_ready(req_read_data_ready),
      .req_write_addr(req_write_addr), .req_write_addr_valid(req_write_addr_valid),
      .req_write_addr_ready(req_write_addr_ready), .req_write_len(req_write_len),
      .req_write_data(req_write_data), .req_write_data_valid(req_write_data_valid),
      .req_write_data_ready(req_write_data_ready),
      .resp_write_status(resp_write_status), .resp_write_status_valid(resp_write_status_valid),
      .resp_write_status_ready(resp_write_status_ready),
      .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we),
      .mem_din(mem_din), .mem_dout(mem_dout)
   );

   // DMem model: contents reload to a known pattern on every reset
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 32'hA500_0000 | 32'(i);
         mem[5] <= 32'hDEAD_BEEF;
      end else if (mem_en) begin
         if (mem_we == 4'hF) mem[mem_addr] <= mem_din;
         mem_dout <= mem[mem_addr];
      end
   end

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (mem_en && (mem_we == 4'h0)) issued = issued + 1;
      if (req_read_data_valid && req_read_data_ready) taken = taken + 1;
      if ((issued - taken) > max_out) max_out = issued - taken;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [31:0] len,
                          input int nbeats, input bit toggle);
      int got;
      int budget;
      got = 0;
      budget = 0;
      req_read_addr = addr;
      req_read_len = len;
      req_read_addr_valid = 1'b1;
      #1;
      while (!req_read_addr_ready && budget < 50) begin
         @(negedge clk); #1; budget++;
      end
      grant_wait = budget;
      check("rd_grant", 32'(req_read_addr_ready), 32'd1);
      @(negedge clk);
      req_read_addr_valid = 1'b0;
      rfire_cyc = cyc;
      budget = 0;
      while (got < nbeats && budget < 200) begin
         req_read_data_ready = toggle ? ((budget % 2) == 0) : 1'b1;
         #1;
         if (req_read_data_valid && req_read_data_ready) begin
            rbuf[got] = req_read_data;
            rcyc[got] = cyc;
            got++;
         end
         @(negedge clk); budget++;
      end
      req_read_data_ready = 1'b0;
      check("rd_beat_count", 32'(got), 32'(nbeats));
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] len, input int nbeats,
                           input logic [31:0] d0, output logic st);
      int budget;
      budget = 0;
      req_write_addr = addr;
      req_write_len = len;
      req_write_addr_valid = 1'b1;
      #1;
      while (!req_write_addr_ready && budget < 50) begin
         @(negedge clk); #1; budget++;
      end
      check("wr_grant", 32'(req_write_addr_ready), 32'd1);
      @(negedge clk);
      req_write_addr_valid = 1'b0;
      for (int i = 0; i < nbeats; i++) begin
         req_write_data = d0 + 32'(i);
         req_write_data_valid = 1'b1;
         budget = 0;
         #1;
         while (!req_write_data_ready && budget < 50) begin
            @(negedge clk); #1; budget++;
         end
         wen[i] = mem_en;
         wwe[i] = mem_we;
         waddr[i] = mem_addr;
         @(negedge clk);
      end
      req_write_data_valid = 1'b0;
      #1;
      check("wr_data_closed", 32'(req_write_data_ready), 32'd0);
      check("wr_status_valid", 32'(resp_write_status_valid), 32'd1);
      st = resp_write_status;
      resp_write_status_ready = 1'b1;
      @(negedge clk);
      resp_write_status_ready = 1'b0;
      #1;
      check("wr_status_done", 32'(resp_write_status_valid), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
      $fatal(1);
   end

   initial begin
      logic st;
      int budget;
      rst = 1'b1;
      req_read_addr = '0;  req_read_addr_valid = 1'b0;  req_read_len = '0;
      req_read_data_ready = 1'b0;
      req_write_addr = '0; req_write_addr_valid = 1'b0; req_write_len = '0;
      req_write_data = '0; req_write_data_valid = 1'b0;
      resp_write_status_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_rd_valid", 32'(req_read_data_valid), 32'd0);
      check("rst_mem_en", 32'(mem_en), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_status_valid", 32'(resp_write_status_valid), 32'd0);
      check("rst_status", 32'(resp_write_status), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Single read: two-cycle latency, then ready again next cycle
      do_read(32'd5, 32'd1, 1, 1'b0);
      check("rd5_data", rbuf[0], 32'hDEAD_BEEF);
      check("rd5_latency", 32'(rcyc[0] - rfire_cyc), 32'd2);
      do_read(32'd5, 32'd1, 1, 1'b0);
      check("rd5_ready_next", 32'(grant_wait), 32'd0);
      check("rd5_data_again", rbuf[0], 32'hDEAD_BEEF);

      // Burst with toggling ready, then with ready held high
      do_read(32'd8, 32'd4, 4, 1'b1);
      for (int i = 0; i < 4; i++) check("rd8_toggle_data", rbuf[i], 32'hA500_0008 + 32'(i));
      #1 check("rd8_toggle_no_extra", 32'(req_read_data_valid), 32'd0);
      @(negedge clk);
      do_read(32'd8, 32'd4, 4, 1'b0);
      for (int i = 0; i < 4; i++) check("rd8_data", rbuf[i], 32'hA500_0008 + 32'(i));
      check("rd8_latency", 32'(rcyc[0] - rfire_cyc), 32'd2);
      check("rd8_back_to_back", 32'(rcyc[3] - rcyc[0]), 32'd3);
      check("max_outstanding_le2", 32'(max_out <= 2), 32'd1);

      // Single write then read-back
      do_write(32'd7, 32'd1, 1, 32'h1234_5678, st);
      check("wr7_mem_en", 32'(wen[0]), 32'd1);
      check("wr7_mem_we", 32'(wwe[0]), 32'hF);
      check("wr7_mem_addr", 32'(waddr[0]), 32'd7);
      check("wr7_status", 32'(st), 32'd1);
      do_read(32'd7, 32'd1, 1, 1'b0);
      check("rd7_data", rbuf[0], 32'h1234_5678);

      // Burst crossing the top of DMem
      do_write(32'h3FFF, 32'd2, 2, 32'h0000_00A0, st);
      check("oor_b0_en", 32'(wen[0]), 32'd1);
      check("oor_b0_we", 32'(wwe[0]), 32'hF);
      check("oor_b0_addr", 32'(waddr[0]), 32'h3FFF);
      check("oor_b1_en", 32'(wen[1]), 32'd0);
      check("oor_b1_we", 32'(wwe[1]), 32'd0);
      check("oor_status", 32'(st), 32'd0);
      check("oor_no_wrap_write", mem[0], 32'hA500_0000);
      do_read(32'h3FFF, 32'd2, 2, 1'b0);
      check("oor_rd_b0", rbuf[0], 32'h0000_00A0);
      check("oor_rd_b1", rbuf[1], 32'd0);

      // Contention from reset: W,R,W,R with len=0 acting as one beat
      @(negedge clk); rst = 1'b1;
      @(negedge clk); @(negedge clk); rst = 1'b0;
      req_write_addr = 32'd40; req_write_len = 32'd0; req_write_addr_valid = 1'b1;
      req_read_addr  = 32'd40; req_read_len  = 32'd0; req_read_addr_valid  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         budget = 0;
         #1;
         while (!(req_write_addr_ready || req_read_addr_ready) && budget < 50) begin
            @(negedge clk); #1; budget++;
         end
         check("rr_not_both", 32'(req_write_addr_ready && req_read_addr_ready), 32'd0);
         check("rr_grant_is_write", 32'(req_write_addr_ready), 32'((k % 2) == 0));
         if (req_write_addr_ready) begin
            do_write(32'd40, 32'd0, 1, 32'h0000_00C0 + 32'(k), st);
            check("rr_wr_status", 32'(st), 32'd1);
            req_write_addr_valid = 1'b1;
         end else begin
            do_read(32'd40, 32'd0, 1, 1'b0);
            check("rr_rd_data", rbuf[0], 32'h0000_00C0 + 32'(k - 1));
            #1 check("rr_rd_single_beat", 32'(req_read_data_valid), 32'd0);
            req_read_addr_valid = 1'b1;
         end
      end
      req_write_addr_valid = 1'b0;
      req_read_addr_valid = 1'b0;
      @(negedge clk);

      // Asynchronous reset in the middle of a long read burst
      req_read_addr = 32'd8; req_read_len = 32'd8; req_read_addr_valid = 1'b1;
      req_read_data_ready = 1'b1;
      budget = 0;
      #1;
      while (!req_read_addr_ready && budget < 50) begin
         @(negedge clk); #1; budget++;
      end
      check("mid_grant", 32'(req_read_addr_ready), 32'd1);
      @(negedge clk);
      req_read_addr_valid = 1'b0;
      @(negedge clk); @(negedge clk);
      #1;
      check("mid_valid_before", 32'(req_read_data_valid), 32'd1);
      check("mid_mem_en_before", 32'(mem_en), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("mid_valid_after_rst", 32'(req_read_data_valid), 32'd0);
      check("mid_mem_en_after_rst", 32'(mem_en), 32'd0);
      req_read_data_ready = 1'b0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      do_read(32'd3, 32'd1, 1, 1'b0);
      check("post_rst_rd3_data", rbuf[0], 32'hA500_0003);
      check("post_rst_rd3_latency", 32'(rcyc[0] - rfire_cyc), 32'd2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
